// File: rtl/pkt_demux.sv
// pkt_demux: routes each whole AXI-stream packet to one of NOUT ports, chosen by a one-hot select taken on the first beat.
// Latency: 1 cycle (single registered output beat); one beat per cycle while the destination port is ready.
// Backpressure: input stalls while the held beat's port is not ready; packets with a bad select are drained without stalling.
// Optional build macro PKTDEMUX_DROPCOUNT_EN adds o_drop_count / i_drop_clear.
module pkt_demux #(
  parameter int NOUT = 4,
  parameter int DW   = 64,
  parameter int BW   = $clog2(DW/8)+1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            S_AXIN_VALID,
  output logic            S_AXIN_READY,
  input  logic [DW-1:0]   S_AXIN_DATA,
  input  logic [BW-1:0]   S_AXIN_BYTES,
  input  logic            S_AXIN_LAST,
  input  logic            S_AXIN_ABORT,
  input  logic [NOUT-1:0] i_sel,
  output logic [NOUT-1:0] M_AXIN_VALID,
  input  logic [NOUT-1:0] M_AXIN_READY,
  output logic [DW-1:0]   M_AXIN_DATA,
  output logic [BW-1:0]   M_AXIN_BYTES,
  output logic            M_AXIN_LAST,
  output logic [NOUT-1:0] M_AXIN_ABORT
`ifdef PKTDEMUX_DROPCOUNT_EN
  ,
  input  logic            i_drop_clear,
  output logic [31:0]     o_drop_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]      state;
  logic [NOUT-1:0] dest;

  logic            sel_onehot;
  logic            out_drain;
  logic            take;
  logic            fwd;
  logic            abort_route;
  logic [NOUT-1:0] fwd_mask;

  assign sel_onehot = (i_sel != '0) && ((i_sel & (i_sel - NOUT'(1))) == '0);

  // The held beat only ever sits on the one port named by M_AXIN_VALID, so its
  // ready alone decides whether the register frees up this cycle.
  assign out_drain = |(M_AXIN_VALID & M_AXIN_READY);

  assign S_AXIN_READY = i_reset_n &&
                        ((state == ST_DROP) || !(|M_AXIN_VALID) || out_drain);

  // An abort beat is never consumed as data: in IDLE it is ignored outright,
  // in ROUTE/DROP it terminates the packet instead.
  assign take        = S_AXIN_VALID && S_AXIN_READY && !S_AXIN_ABORT;
  assign abort_route = (state == ST_ROUTE) && S_AXIN_ABORT;
  assign fwd         = take && (((state == ST_IDLE) && sel_onehot) || (state == ST_ROUTE));
  assign fwd_mask    = (state == ST_IDLE) ? i_sel : dest;

  // Packet framing: pick route or drop on the first beat, return to IDLE on LAST or abort.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      dest  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            dest <= i_sel;
            if (!S_AXIN_LAST)
              state <= sel_onehot ? ST_ROUTE : ST_DROP;
          end
        end
        ST_ROUTE: begin
          if (S_AXIN_ABORT || (take && S_AXIN_LAST))
            state <= ST_IDLE;
        end
        ST_DROP: begin
          if (S_AXIN_ABORT || (take && S_AXIN_LAST))
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single output beat register; abort wins over load, load wins over drain.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      M_AXIN_VALID <= '0;
      M_AXIN_ABORT <= '0;
      M_AXIN_DATA  <= '0;
      M_AXIN_BYTES <= '0;
      M_AXIN_LAST  <= 1'b0;
    end else begin
      M_AXIN_ABORT <= '0;
      if (abort_route) begin
        M_AXIN_VALID <= '0;
        M_AXIN_ABORT <= dest;
      end else if (fwd) begin
        M_AXIN_VALID <= fwd_mask;
        M_AXIN_DATA  <= S_AXIN_DATA;
        M_AXIN_BYTES <= S_AXIN_BYTES;
        M_AXIN_LAST  <= S_AXIN_LAST;
      end else if (out_drain) begin
        M_AXIN_VALID <= '0;
      end
    end
  end

`ifdef PKTDEMUX_DROPCOUNT_EN
  logic drop_evt;

  // A packet counts once: when its first beat carries a bad select, or when a routed packet is aborted.
  assign drop_evt = ((state == ST_IDLE) && take && !sel_onehot) || abort_route;

  // Saturating drop counter; clear has priority over increment.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      o_drop_count <= '0;
    else if (i_drop_clear)
      o_drop_count <= '0;
    else if (drop_evt && (o_drop_count != 32'hFFFF_FFFF))
      o_drop_count <= o_drop_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pkt_demux.sv
// tb_pkt_demux: table-driven single-beat routing, hand-written multi-cycle sequences, then randomized traffic
// checked against a packet-level scoreboard.
// Inputs are driven 1 time unit after the rising edge; handshakes are observed on the falling edge.
module tb_pkt_demux;
  localparam int NOUT = 4;
  localparam int DW   = 64;
  localparam int BW   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid, s_ready, s_last, s_abort;
  logic [DW-1:0]   s_data;
  logic [BW-1:0]   s_bytes;
  logic [NOUT-1:0] sel;
  logic [NOUT-1:0] m_valid, m_ready, m_abort;
  logic [DW-1:0]   m_data;
  logic [BW-1:0]   m_bytes;
  logic            m_last;
`ifdef PKTDEMUX_DROPCOUNT_EN
  logic            drop_clear;
  logic [31:0]     drop_count;
`endif

  pkt_demux #(.NOUT(NOUT), .DW(DW), .BW(BW)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .S_AXIN_VALID (s_valid),
    .S_AXIN_READY (s_ready),
    .S_AXIN_DATA  (s_data),
    .S_AXIN_BYTES (s_bytes),
    .S_AXIN_LAST  (s_last),
    .S_AXIN_ABORT (s_abort),
    .i_sel        (sel),
    .M_AXIN_VALID (m_valid),
    .M_AXIN_READY (m_ready),
    .M_AXIN_DATA  (m_data),
    .M_AXIN_BYTES (m_bytes),
    .M_AXIN_LAST  (m_last),
    .M_AXIN_ABORT (m_abort)
`ifdef PKTDEMUX_DROPCOUNT_EN
    ,
    .i_drop_clear (drop_clear),
    .o_drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    sel;
    logic [DW-1:0] data;
    logic [BW-1:0] bytes;
    logic [3:0]    exp_vld;
  } vec_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic [BW-1:0] bytes;
    logic          last;
  } beat_t;

  beat_t dlv_q[$];        // beats delivered during hand-written tests
  beat_t exp_q[$];        // scoreboard: beats accepted for a routed packet, not yet delivered
  int    exp_abort_q[$];  // ports expected to see an abort pulse
  int    n_checks = 0;
  int    n_errors = 0;
  bit    rand_on = 1'b0;
  int    cur_port = -1;   // model's destination for the packet being driven, -1 = dropped
  logic [3:0] bad_sel [5] = '{4'b0000, 4'b0011, 4'b0101, 4'b1100, 4'b1111};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0;
    sel = '0; s_data = '0; s_bytes = '0;
  endtask

  task automatic drive(input logic [3:0] sl, input logic [DW-1:0] d, input logic [BW-1:0] b, input logic lst);
    s_valid = 1'b1; sel = sl; s_data = d; s_bytes = b; s_last = lst; s_abort = 1'b0;
  endtask

  // Output monitor: logs deliveries in directed mode, checks the scoreboard in random mode.
  always @(negedge clk) begin
    if (rand_on) begin
      if (m_abort != '0) begin
        if (exp_abort_q.size() == 0) begin
          chk("rnd_abort_unexpected", 64'(m_abort), 64'd0);
        end else begin
          int p;
          p = exp_abort_q.pop_front();
          chk("rnd_abort_port", 64'(m_abort), 64'd1 << p);
        end
        chk("rnd_abort_pending_le1", 64'(exp_q.size() <= 1), 64'd1);
        exp_q.delete();
      end
      chk("rnd_valid_onehot", 64'($countones(m_valid) <= 1), 64'd1);
      for (int k = 0; k < NOUT; k++) begin
        if (m_valid[k] && m_ready[k]) begin
          if (exp_q.size() == 0) begin
            chk("rnd_extra_beat", 64'(exp_q.size()), 64'd1);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("rnd_port", 64'(k), 64'(e.port));
            chk("rnd_data", m_data, e.data);
            chk("rnd_last", 64'(m_last), 64'(e.last));
            if (e.last) chk("rnd_bytes", 64'(m_bytes), 64'(e.bytes));
          end
        end
      end
      if (s_valid && s_ready && !s_abort && cur_port >= 0)
        exp_q.push_back('{cur_port, s_data, s_bytes, s_last});
    end else begin
      for (int k = 0; k < NOUT; k++)
        if (m_valid[k] && m_ready[k])
          dlv_q.push_back('{k, m_data, m_bytes, m_last});
    end
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    vec_t          vt [7];
    logic [DW-1:0] bp_d [4];
    int            len, idx, ab_idx, exp_drops;
    logic [3:0]    psel;
    bit            pkt_active, ended;

    vt[0] = '{4'b0100, 64'h1122334455667788, 4'd8, 4'b0100};
    vt[1] = '{4'b0001, 64'h0123456789ABCDEF, 4'd3, 4'b0001};
    vt[2] = '{4'b1000, 64'hDEADBEEFCAFEF00D, 4'd1, 4'b1000};
    vt[3] = '{4'b0010, 64'h00000000000000FF, 4'd8, 4'b0010};
    vt[4] = '{4'b0000, 64'hAAAAAAAAAAAAAAAA, 4'd5, 4'b0000};
    vt[5] = '{4'b0011, 64'h5555555555555555, 4'd2, 4'b0000};
    vt[6] = '{4'b1111, 64'h1234123412341234, 4'd7, 4'b0000};

    // ---- reset state ----
    idle_in();
    m_ready = 4'b1111;
`ifdef PKTDEMUX_DROPCOUNT_EN
    drop_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_abort", 64'(m_abort), 64'd0);
    chk("rst_m_last",  64'(m_last),  64'd0);
    chk("rst_m_data",  m_data,       64'd0);
    chk("rst_m_bytes", 64'(m_bytes), 64'd0);
    rst_n = 1'b1;
    tick();

    // ---- table: single-beat packets, good and bad selects ----
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].sel, vt[i].data, vt[i].bytes, 1'b1);
      chk("tbl_s_ready", 64'(s_ready), 64'd1);
      tick();
      idle_in();
      chk("tbl_m_valid", 64'(m_valid), 64'(vt[i].exp_vld));
      if (vt[i].exp_vld != 4'b0000) begin
        chk("tbl_m_data",  m_data,       vt[i].data);
        chk("tbl_m_bytes", 64'(m_bytes), 64'(vt[i].bytes));
        chk("tbl_m_last",  64'(m_last),  64'd1);
      end
      tick();
      chk("tbl_drained", 64'(m_valid), 64'd0);
    end

    // ---- back-pressure: 4 beats to port 1, port 1 stalled 3 cycles on beat 2 ----
    dlv_q.delete();
    bp_d[0] = 64'hB000_0000_0000_0000; bp_d[1] = 64'hB111_1111_1111_1111;
    bp_d[2] = 64'hB222_2222_2222_2222; bp_d[3] = 64'hB333_3333_3333_3333;
    drive(4'b0010, bp_d[0], 4'd8, 1'b0);
    chk("bp_s_ready0", 64'(s_ready), 64'd1);
    tick();
    chk("bp_m_valid0", 64'(m_valid), 64'b0010);
    drive(4'b1000, bp_d[1], 4'd8, 1'b0);   // sel on later beats must be ignored
    tick();
    m_ready = 4'b1101;
    drive(4'b0001, bp_d[2], 4'd8, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_s_ready", 64'(s_ready), 64'd0);
      chk("bp_hold_valid",    64'(m_valid), 64'b0010);
      chk("bp_hold_data",     m_data,       bp_d[1]);
      tick();
    end
    m_ready = 4'b1111;
    #1;
    chk("bp_resume_s_ready", 64'(s_ready), 64'd1);
    tick();
    drive(4'b0100, bp_d[3], 4'd6, 1'b1);
    tick();
    idle_in();
    tick();
    tick();
    chk("bp_count", 64'(dlv_q.size()), 64'd4);
    if (dlv_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("bp_port", 64'(dlv_q[i].port), 64'd1);
        chk("bp_data", dlv_q[i].data, bp_d[i]);
      end
      chk("bp_last",  64'(dlv_q[3].last),  64'd1);
      chk("bp_bytes", 64'(dlv_q[3].bytes), 64'd6);
    end

    // ---- drop on bad select: 3-beat packets with sel 0000 then 0011 ----
`ifdef PKTDEMUX_DROPCOUNT_EN
    drop_clear = 1'b1;
    tick();
    drop_clear = 1'b0;
`endif
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) begin
        drive((b == 0) ? ((p == 0) ? 4'b0000 : 4'b0011) : 4'b0001,
              64'hD0D0 + 64'(p * 16 + b), 4'd8, b == 2);
        chk("drop_s_ready", 64'(s_ready), 64'd1);
        tick();
        chk("drop_m_valid", 64'(m_valid), 64'd0);
      end
    end
    idle_in();
    tick();
`ifdef PKTDEMUX_DROPCOUNT_EN
    chk("drop_count", 64'(drop_count), 64'd2);
`endif

    // ---- abort mid-packet to port 3 while port 3 is stalled ----
    dlv_q.delete();
    drive(4'b1000, 64'hA0, 4'd8, 1'b0);
    tick();
    drive(4'b1000, 64'hA1, 4'd8, 1'b0);
    tick();
    m_ready = 4'b0111;
    drive(4'b0000, 64'hA2, 4'd8, 1'b0);
    s_abort = 1'b1;
    tick();
    idle_in();
    chk("abort_pulse",   64'(m_abort), 64'b1000);
    chk("abort_cleared", 64'(m_valid), 64'd0);
    tick();
    chk("abort_one_cycle", 64'(m_abort), 64'd0);
    m_ready = 4'b1111;
    drive(4'b0001, 64'hE0, 4'd8, 1'b0);
    tick();
    drive(4'b0000, 64'hE1, 4'd4, 1'b1);
    tick();
    idle_in();
    tick();
    tick();
    chk("abort_dlv_count", 64'(dlv_q.size()), 64'd3);
    if (dlv_q.size() == 3) begin
      chk("abort_dlv0_port", 64'(dlv_q[0].port), 64'd3);
      chk("abort_dlv0_data", dlv_q[0].data, 64'hA0);
      chk("abort_dlv1_port", 64'(dlv_q[1].port), 64'd0);
      chk("abort_dlv1_data", dlv_q[1].data, 64'hE0);
      chk("abort_dlv2_data", dlv_q[2].data, 64'hE1);
      chk("abort_dlv2_last", 64'(dlv_q[2].last), 64'd1);
    end

    // ---- abort in IDLE is ignored, the beat with it is not taken ----
    drive(4'b0001, 64'h1D1E, 4'd8, 1'b1);
    s_abort = 1'b1;
    tick();
    idle_in();
    chk("idle_abort_no_pulse", 64'(m_abort), 64'd0);
    chk("idle_abort_no_valid", 64'(m_valid), 64'd0);
    drive(4'b0001, 64'h600D, 4'd8, 1'b1);
    tick();
    idle_in();
    chk("after_idle_abort_valid", 64'(m_valid), 64'b0001);
    chk("after_idle_abort_data",  m_data,       64'h600D);
    tick();

    // ---- back-to-back packets: port 0 then port 2, no bubble ----
    for (int i = 0; i < 4; i++) begin
      drive((i < 2) ? 4'b0001 : 4'b0100, 64'hBB00 + 64'(i), 4'd8, (i % 2) == 1);
      chk("b2b_s_ready", 64'(s_ready), 64'd1);
      tick();
      chk("b2b_m_valid", 64'(m_valid), (i < 2) ? 64'b0001 : 64'b0100);
      chk("b2b_m_data",  m_data,       64'hBB00 + 64'(i));
    end
    idle_in();
    tick();

    // ---- asynchronous reset mid-packet ----
    m_ready = 4'b1011;
    drive(4'b0100, 64'hF0, 4'd8, 1'b0);
    tick();
    idle_in();
    chk("arst_pre_valid", 64'(m_valid), 64'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",   64'(m_valid), 64'd0);
    chk("arst_abort",   64'(m_abort), 64'd0);
    chk("arst_data",    m_data,       64'd0);
    chk("arst_s_ready", 64'(s_ready), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("arst_no_abort", 64'(m_abort), 64'd0);
    m_ready = 4'b1111;
    drive(4'b0010, 64'h6060, 4'd5, 1'b1);
    tick();
    idle_in();
    chk("arst_next_valid", 64'(m_valid), 64'b0010);
    chk("arst_next_data",  m_data,       64'h6060);
    tick();

    // ---- randomized traffic against the packet-level model ----
    exp_q.delete();
    exp_abort_q.delete();
    exp_drops = 0;
`ifdef PKTDEMUX_DROPCOUNT_EN
    drop_clear = 1'b1;
    tick();
    drop_clear = 1'b0;
`endif
    rand_on = 1'b1;
    pkt_active = 1'b0;
    len = 0; idx = 0; ab_idx = -1; psel = '0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (cyc >= 2500 && !pkt_active && !s_valid) break;
      if (!pkt_active) begin
        len = $urandom_range(1, 5);
        if ($urandom_range(0, 3) != 0) psel = 4'b0001 << $urandom_range(0, 3);
        else                           psel = bad_sel[$urandom_range(0, 4)];
        cur_port = -1;
        for (int k = 0; k < NOUT; k++)
          if (psel == (4'b0001 << k)) cur_port = k;
        ab_idx = (len >= 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : -1;
        idx = 0;
        pkt_active = 1'b1;
      end
      if (!s_valid && $urandom_range(0, 4) != 0) begin
        drive((idx == 0) ? psel : 4'($urandom), {$urandom, $urandom},
              4'($urandom_range(1, 8)), idx == len - 1);
        s_abort = (idx == ab_idx);
      end
      m_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      ended = 1'b0;
      @(negedge clk);
      if (s_valid) begin
        if (s_abort) begin
          if (cur_port >= 0) begin
            exp_abort_q.push_back(cur_port);
            exp_drops++;
          end
          pkt_active = 1'b0;
          ended = 1'b1;
        end else if (s_ready) begin
          if (idx == 0 && cur_port < 0) exp_drops++;
          if (s_last) pkt_active = 1'b0;
          idx++;
          ended = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (ended) idle_in();
    end
    idle_in();
    m_ready = 4'b1111;
    repeat (4) tick();
    chk("rnd_all_delivered",  64'(exp_q.size()),       64'd0);
    chk("rnd_all_aborts_seen", 64'(exp_abort_q.size()), 64'd0);
`ifdef PKTDEMUX_DROPCOUNT_EN
    chk("rnd_drop_count", 64'(drop_count), 64'(exp_drops));
`endif
    rand_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
